// File: rtl/motor_pkg.sv
// Shared types, constants and decode helpers for the two-channel motor PWM driver.
package motor_pkg;

  localparam int DUTY_W = 4;

  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN_FWD = 2'd1,
    ST_RUN_REV = 2'd2,
    ST_COAST   = 2'd3
  } chan_state_t;

  typedef enum logic [1:0] {
    DIR_STOP = 2'd0,
    DIR_FWD  = 2'd1,
    DIR_REV  = 2'd2
  } dir_t;

  function automatic dir_t decode_dir(input logic a, input logic b);
    dir_t d;
    case ({a, b})
      2'b10:   d = DIR_FWD;
      2'b01:   d = DIR_REV;
      default: d = DIR_STOP;
    endcase
    return d;
  endfunction

  function automatic chan_state_t run_state(input dir_t d);
    chan_state_t s;
    case (d)
      DIR_FWD: s = ST_RUN_FWD;
      DIR_REV: s = ST_RUN_REV;
      default: s = ST_STOP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Command and gate-drive bundle between a motion controller and the PWM driver.
interface motor_pwm_driver_if;
  import motor_pkg::*;

  logic              m1_a;
  logic              m1_b;
  logic              m2_a;
  logic              m2_b;
  logic [DUTY_W-1:0] dc1;
  logic [DUTY_W-1:0] dc2;
  logic              m1_in1;
  logic              m1_in2;
  logic              m2_in1;
  logic              m2_in2;
  logic              period_start;

  modport master (
    output m1_a, m1_b, m2_a, m2_b, dc1, dc2,
    input  m1_in1, m1_in2, m2_in1, m2_in2, period_start
  );

  modport slave (
    input  m1_a, m1_b, m2_a, m2_b, dc1, dc2,
    output m1_in1, m1_in2, m2_in1, m2_in2, period_start
  );

endinterface

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: samples its request at each period boundary, coasts on
// direction reversal, and drives registered gate outputs from the shared phase.
module motor_pwm_channel
  import motor_pkg::*;
#(
  parameter int DEADTIME = 2
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              boundary,
  input  logic [DUTY_W-1:0] phase,
  input  logic              dir_a,
  input  logic              dir_b,
  input  logic [DUTY_W-1:0] duty,
  output logic              in1,
  output logic              in2
);

  dir_t              req_s;
  chan_state_t       state_r;
  logic [3:0]        dead_r;
  logic [DUTY_W-1:0] duty_r;
  logic              in1_r;
  logic              in2_r;

  assign req_s = decode_dir(dir_a, dir_b);
  assign in1   = in1_r;
  assign in2   = in2_r;

  // Channel FSM with dead-time counter, sampled duty and gate registers.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_STOP;
      dead_r  <= 4'd0;
      duty_r  <= {DUTY_W{1'b0}};
      in1_r   <= 1'b0;
      in2_r   <= 1'b0;
    end else begin
      // Gates derive from the state only, so in1/in2 can never both be high.
      in1_r <= (state_r == ST_RUN_FWD) && (phase < duty_r);
      in2_r <= (state_r == ST_RUN_REV) && (phase < duty_r);
      if (boundary) begin
        // During COAST duty_r doubles as the pending duty; the pending
        // direction is simply the latest sampled request.
        duty_r <= duty;
        case (state_r)
          ST_STOP: begin
            state_r <= run_state(req_s);
          end
          ST_RUN_FWD: begin
            if (req_s == DIR_REV) begin
              state_r <= ST_COAST;
              dead_r  <= 4'(DEADTIME);
            end else begin
              state_r <= run_state(req_s);
            end
          end
          ST_RUN_REV: begin
            if (req_s == DIR_FWD) begin
              state_r <= ST_COAST;
              dead_r  <= 4'(DEADTIME);
            end else begin
              state_r <= run_state(req_s);
            end
          end
          ST_COAST: begin
            if (dead_r > 4'd1) begin
              dead_r <= dead_r - 4'd1;
            end else begin
              dead_r  <= 4'd0;
              state_r <= run_state(req_s);
            end
          end
          default: begin
            state_r <= ST_STOP;
            dead_r  <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual H-bridge PWM driver: shared prescaler and 16-step phase counter feeding
// two independent motor channels.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PRESCALE = 49,
  parameter int DEADTIME = 2
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  motor_pwm_driver_if.slave bus
);

  localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

  logic [PW-1:0]     presc_r;
  logic [DUTY_W-1:0] phase_r;
  logic              period_start_r;
  logic              step_s;
  logic              boundary_s;

  assign step_s           = (presc_r == PW'(PRESCALE));
  assign boundary_s       = step_s && (phase_r == {DUTY_W{1'b1}});
  assign bus.period_start = period_start_r;

  // Prescaler, phase counter and period-start pulse.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      presc_r        <= {PW{1'b0}};
      phase_r        <= {DUTY_W{1'b0}};
      period_start_r <= 1'b0;
    end else begin
      presc_r        <= step_s ? {PW{1'b0}} : presc_r + PW'(1);
      period_start_r <= boundary_s;
      if (step_s) begin
        phase_r <= phase_r + {{(DUTY_W-1){1'b0}}, 1'b1};
      end
    end
  end

  motor_pwm_channel #(.DEADTIME(DEADTIME)) u_ch1 (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .boundary (boundary_s),
    .phase    (phase_r),
    .dir_a    (bus.m1_a),
    .dir_b    (bus.m1_b),
    .duty     (bus.dc1),
    .in1      (bus.m1_in1),
    .in2      (bus.m1_in2)
  );

  motor_pwm_channel #(.DEADTIME(DEADTIME)) u_ch2 (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .boundary (boundary_s),
    .phase    (phase_r),
    .dir_a    (bus.m2_a),
    .dir_b    (bus.m2_b),
    .duty     (bus.dc2),
    .in1      (bus.m2_in1),
    .in2      (bus.m2_in2)
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Self-checking bench for motor_pwm_driver: directed scenarios plus random
// direction/duty traffic against a period-level behavioural model.
module tb_motor_pwm_driver;
  import motor_pkg::*;

  localparam int DT  = 2;
  localparam int PER = 16;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;

  motor_pwm_driver_if bus();

  motor_pwm_driver #(.PRESCALE(0), .DEADTIME(DT)) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk_50M = ~clk_50M;

  int n_checks = 0;
  int n_pass   = 0;
  int n_edges  = 0;
  // Model per motor: mode 0=stop 1=fwd 2=rev 3=coast, coast periods left, duty.
  int md[2];
  int cl[2];
  int du[2];
  int last_dir[2];
  int gap[2];
  int cnt[4];
  logic [4:0] exp_out;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int req_of(input logic a, input logic b);
    if (a && !b) return 1;
    if (!a && b) return 2;
    return 0;
  endfunction

  task automatic reset_model();
    n_edges = 0;
    for (int m = 0; m < 2; m++) begin
      md[m] = 0; cl[m] = 0; du[m] = 0; last_dir[m] = 0; gap[m] = 0;
    end
  endtask

  // Expected outputs for this edge come from the pre-edge phase and mode.
  task automatic model_edge();
    int ph;
    int r[2];
    if (!rst_n) begin
      reset_model();
      exp_out = 5'd0;
      return;
    end
    ph = n_edges % PER;
    exp_out[4] = (md[0] == 1) && (ph < du[0]);
    exp_out[3] = (md[0] == 2) && (ph < du[0]);
    exp_out[2] = (md[1] == 1) && (ph < du[1]);
    exp_out[1] = (md[1] == 2) && (ph < du[1]);
    n_edges++;
    exp_out[0] = (n_edges % PER == 0);
    if (n_edges % PER == 0) begin
      r[0] = req_of(bus.m1_a, bus.m1_b);
      r[1] = req_of(bus.m2_a, bus.m2_b);
      du[0] = int'(bus.dc1);
      du[1] = int'(bus.dc2);
      for (int m = 0; m < 2; m++) begin
        if (md[m] == 3) begin
          if (cl[m] > 1) cl[m]--;
          else begin cl[m] = 0; md[m] = r[m]; end
        end else if ((md[m] == 1 && r[m] == 2) || (md[m] == 2 && r[m] == 1)) begin
          md[m] = 3; cl[m] = DT;
        end else begin
          md[m] = r[m];
        end
      end
    end
  endtask

  task automatic tick();
    int d;
    logic a;
    logic b;
    @(posedge clk_50M);
    model_edge();
    #1;
    check_eq("gates", int'({bus.m1_in1, bus.m1_in2, bus.m2_in1, bus.m2_in2, bus.period_start}),
             int'(exp_out));
    check_eq("mutex", int'((bus.m1_in1 & bus.m1_in2) | (bus.m2_in1 & bus.m2_in2)), 0);
    // Opposite drives must be separated by at least one full idle period.
    for (int m = 0; m < 2; m++) begin
      a = (m == 0) ? bus.m1_in1 : bus.m2_in1;
      b = (m == 0) ? bus.m1_in2 : bus.m2_in2;
      d = a ? 1 : (b ? 2 : 0);
      if (d == 0) gap[m]++;
      else begin
        if (last_dir[m] != 0 && d != last_dir[m])
          check_eq("no_direct_reverse", int'(gap[m] >= PER), 1);
        last_dir[m] = d;
        gap[m] = 0;
      end
    end
    cnt[0] += int'(bus.m1_in1);
    cnt[1] += int'(bus.m1_in2);
    cnt[2] += int'(bus.m2_in1);
    cnt[3] += int'(bus.m2_in2);
  endtask

  task automatic tick_to(input int p);
    tick();
    while (n_edges % PER != p) tick();
  endtask

  task automatic run_count(input int cycles);
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // d: 0=stop 1=fwd 2=rev 3=a and b both high.
  task automatic set_m(input int m, input int d, input int duty);
    logic a;
    logic b;
    a = (d == 1) || (d == 3);
    b = (d == 2) || (d == 3);
    if (m == 0) begin bus.m1_a = a; bus.m1_b = b; bus.dc1 = 4'(duty); end
    else        begin bus.m2_a = a; bus.m2_b = b; bus.dc2 = 4'(duty); end
  endtask

  initial begin
    int found;
    reset_model();
    set_m(0, 0, 0);
    set_m(1, 0, 0);
    exp_out = 5'd0;

    repeat (3) tick();
    check_eq("reset_out", int'({bus.m1_in1, bus.m1_in2, bus.m2_in1, bus.m2_in2, bus.period_start}), 0);
    @(negedge clk_50M);
    rst_n = 1'b1;

    // Forward at half duty.
    set_m(0, 1, 8);
    run_count(32);
    run_count(16);
    check_eq("duty8_in1", cnt[0], 8);
    check_eq("duty8_in2", cnt[1], 0);

    // Mid-period duty change applies only from the next period.
    set_m(0, 1, 4);
    tick_to(0);
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (i == 4) set_m(0, 1, 12);
    end
    check_eq("sample_cur", cnt[0], 4);
    run_count(16);
    check_eq("sample_next", cnt[0], 12);

    // Reversal goes through DT coast periods.
    tick_to(3);
    set_m(0, 2, 8);
    tick_to(0);
    run_count(DT * PER);
    check_eq("coast_zero", cnt[0] + cnt[1], 0);
    run_count(1);
    check_eq("rev_in2", cnt[1], 1);
    check_eq("rev_in1", cnt[0], 0);

    // Invalid direction and zero duty.
    set_m(1, 3, 9);
    tick_to(0);
    run_count(32);
    check_eq("ab_both", cnt[2] + cnt[3], 0);
    set_m(1, 1, 0);
    tick_to(0);
    run_count(32);
    check_eq("duty0", cnt[2], 0);

    // Reset in the middle of a coast with motor 2 actively driving.
    set_m(0, 1, 10);
    set_m(1, 1, 15);
    tick_to(0);
    repeat (7) tick();
    check_eq("pre_reset_m2", int'(bus.m2_in1), 1);
    rst_n = 1'b0;
    #1;
    check_eq("reset_async", int'({bus.m1_in1, bus.m1_in2, bus.m2_in1, bus.m2_in2, bus.period_start}), 0);
    reset_model();
    repeat (3) tick();
    @(negedge clk_50M);
    rst_n = 1'b1;
    found = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (bus.period_start && found == 0) found = i;
    end
    check_eq("first_period_start", found, PER);

    // Random traffic, roughly one input change per period.
    for (int p = 0; p < 1500; p++) begin
      for (int s = 0; s < PER; s++) begin
        tick();
        if ($urandom_range(0, 15) == 0)
          set_m(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
